// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: opcodes, funct fields, ALU operation codes and the ID/EX
// register layout.
package rv32_pkg;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        AluAdd   = 4'd0,
        AluSub   = 4'd1,
        AluSll   = 4'd2,
        AluSlt   = 4'd3,
        AluSltu  = 4'd4,
        AluXor   = 4'd5,
        AluSrl   = 4'd6,
        AluSra   = 4'd7,
        AluOr    = 4'd8,
        AluAnd   = 4'd9,
        AluPassB = 4'd10,
        AluPc4   = 4'd11
    } alu_op_e;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic branch;
        logic jump;
        logic illegal;
    } ctrl_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        alu_op_e         alu_op;
        ctrl_t           ctrl;
    } idex_t;

    // alt selects SUB/SRA; callers gate it so that e.g. ADDI never becomes SUB.
    function automatic alu_op_e alu_decode(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        op = AluAdd;
        case (funct3)
            F3_ADD_SUB: op = alt ? AluSub : AluAdd;
            F3_SLL:     op = AluSll;
            F3_SLT:     op = AluSlt;
            F3_SLTU:    op = AluSltu;
            F3_XOR:     op = AluXor;
            F3_SRL_SRA: op = alt ? AluSra : AluSrl;
            F3_OR:      op = AluOr;
            F3_AND:     op = AluAnd;
            default:    op = AluAdd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator: selects the I/S/B/U/J format from the opcode
// and sign-extends to XLEN. Formats without an immediate yield zero.
module imm_gen
    import rv32_pkg::*;
(
    input  logic [31:0]     insn_i,
    output logic [XLEN-1:0] imm_o
);

    always_comb begin
        imm_o = '0;
        case (insn_i[6:0])
            OPC_LUI, OPC_AUIPC:
                imm_o = {insn_i[31:12], 12'b0};
            OPC_JAL:
                imm_o = {{12{insn_i[31]}}, insn_i[19:12], insn_i[20], insn_i[30:21], 1'b0};
            OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_FENCE:
                imm_o = {{20{insn_i[31]}}, insn_i[31:20]};
            OPC_BRANCH:
                imm_o = {{20{insn_i[31]}}, insn_i[7], insn_i[30:25], insn_i[11:8], 1'b0};
            OPC_STORE:
                imm_o = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
            default:
                imm_o = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decodes the IF/ID word, reads operands with write-back bypass,
// detects load-use hazards and registers the result into ID/EX.
module id_stage
    import rv32_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] IF_ID_PC,
    input  logic [31:0]     IF_ID_Instruction,
    input  logic            IF_ID_enable,
    input  logic            combined_stall,
    input  logic            flush,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_rdata,
    input  logic [XLEN-1:0] rs2_rdata,
    input  logic            wb_RegWrite,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            load_use_stall,
    output logic            ID_EX_valid,
    output logic [XLEN-1:0] ID_EX_PC,
    output logic [XLEN-1:0] ID_EX_rs1_data,
    output logic [XLEN-1:0] ID_EX_rs2_data,
    output logic [XLEN-1:0] ID_EX_imm,
    output logic [4:0]      ID_EX_rs1,
    output logic [4:0]      ID_EX_rs2,
    output logic [4:0]      ID_EX_rd,
    output logic [2:0]      ID_EX_funct3,
    output alu_op_e         ID_EX_alu_op,
    output logic            ID_EX_RegWrite,
    output logic            ID_EX_MemRead,
    output logic            ID_EX_MemWrite,
    output logic            ID_EX_MemToReg,
    output logic            ID_EX_ALUSrc,
    output logic            ID_EX_Branch,
    output logic            ID_EX_Jump,
    output logic            ID_EX_illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    ctrl_t           ctrl;
    alu_op_e         alu_op;
    logic            legal, rs1_used, rs2_used, has_rd;
    logic [XLEN-1:0] rs1_val, rs2_val;
    idex_t           idex_q, idex_d;

    assign opcode   = IF_ID_Instruction[6:0];
    assign funct3   = IF_ID_Instruction[14:12];
    assign funct7   = IF_ID_Instruction[31:25];
    assign rs1_addr = IF_ID_Instruction[19:15];
    assign rs2_addr = IF_ID_Instruction[24:20];

    imm_gen u_imm_gen (
        .insn_i (IF_ID_Instruction),
        .imm_o  (imm)
    );

    always_comb begin
        ctrl     = '0;
        alu_op   = AluAdd;
        legal    = 1'b1;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        has_rd   = 1'b1;
        case (opcode)
            OPC_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                alu_op         = AluPassB;
            end
            OPC_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OPC_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
                alu_op         = AluPc4;
            end
            OPC_JALR: begin
                legal          = (funct3 == 3'b000);
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.alu_src   = 1'b1;
                alu_op         = AluPc4;
                rs1_used       = 1'b1;
            end
            OPC_BRANCH: begin
                legal       = !(funct3 inside {3'b010, 3'b011});
                ctrl.branch = 1'b1;
                alu_op      = AluSub;
                rs1_used    = 1'b1;
                rs2_used    = 1'b1;
                has_rd      = 1'b0;
            end
            OPC_LOAD: begin
                legal           = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = 1'b1;
                rs1_used        = 1'b1;
            end
            OPC_STORE: begin
                legal          = funct3 inside {3'b000, 3'b001, 3'b010};
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
                has_rd         = 1'b0;
            end
            OPC_OP_IMM: begin
                if (funct3 == F3_SLL) begin
                    legal = (funct7 == F7_BASE);
                end else if (funct3 == F3_SRL_SRA) begin
                    legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                end
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                alu_op         = alu_decode(funct3, (funct3 == F3_SRL_SRA) && funct7[5]);
                rs1_used       = 1'b1;
            end
            OPC_OP: begin
                legal = (funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && (funct3 inside {F3_ADD_SUB, F3_SRL_SRA}));
                ctrl.reg_write = 1'b1;
                alu_op         = alu_decode(funct3, funct7[5]);
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
            end
            OPC_FENCE: begin
                legal = (funct3 == 3'b000);
            end
            default: legal = 1'b0;
        endcase
        // Illegal words travel down the pipe as inert, operand-free instructions.
        if (!legal) begin
            ctrl     = '0;
            alu_op   = AluAdd;
            rs1_used = 1'b0;
            rs2_used = 1'b0;
        end
        ctrl.illegal = !legal;
    end

    // rsN_addr==0 also covers wb_rd==0, so x0 is never bypassed.
    always_comb begin
        rs1_val = rs1_rdata;
        rs2_val = rs2_rdata;
        if (rs1_addr == 5'd0) begin
            rs1_val = '0;
        end else if (wb_RegWrite && (wb_rd == rs1_addr)) begin
            rs1_val = wb_data;
        end
        if (rs2_addr == 5'd0) begin
            rs2_val = '0;
        end else if (wb_RegWrite && (wb_rd == rs2_addr)) begin
            rs2_val = wb_data;
        end
    end

    assign load_use_stall = IF_ID_enable && idex_q.valid && idex_q.ctrl.mem_read &&
                            (idex_q.rd != 5'd0) &&
                            ((rs1_used && (idex_q.rd == rs1_addr)) ||
                             (rs2_used && (idex_q.rd == rs2_addr)));

    always_comb begin
        idex_d        = '0;
        idex_d.alu_op = AluAdd;
        if (flush) begin
            idex_d.valid = 1'b0;
        end else if (combined_stall) begin
            idex_d = idex_q;
        end else if (load_use_stall || !IF_ID_enable) begin
            idex_d.valid = 1'b0;
        end else begin
            idex_d.valid    = 1'b1;
            idex_d.pc       = IF_ID_PC;
            idex_d.rs1_data = rs1_val;
            idex_d.rs2_data = rs2_val;
            idex_d.imm      = imm;
            idex_d.rs1      = rs1_addr;
            idex_d.rs2      = rs2_addr;
            idex_d.rd       = has_rd ? IF_ID_Instruction[11:7] : 5'd0;
            idex_d.funct3   = funct3;
            idex_d.alu_op   = alu_op;
            idex_d.ctrl     = ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign ID_EX_valid    = idex_q.valid;
    assign ID_EX_PC       = idex_q.pc;
    assign ID_EX_rs1_data = idex_q.rs1_data;
    assign ID_EX_rs2_data = idex_q.rs2_data;
    assign ID_EX_imm      = idex_q.imm;
    assign ID_EX_rs1      = idex_q.rs1;
    assign ID_EX_rs2      = idex_q.rs2;
    assign ID_EX_rd       = idex_q.rd;
    assign ID_EX_funct3   = idex_q.funct3;
    assign ID_EX_alu_op   = idex_q.alu_op;
    assign ID_EX_RegWrite = idex_q.ctrl.reg_write;
    assign ID_EX_MemRead  = idex_q.ctrl.mem_read;
    assign ID_EX_MemWrite = idex_q.ctrl.mem_write;
    assign ID_EX_MemToReg = idex_q.ctrl.mem_to_reg;
    assign ID_EX_ALUSrc   = idex_q.ctrl.alu_src;
    assign ID_EX_Branch   = idex_q.ctrl.branch;
    assign ID_EX_Jump     = idex_q.ctrl.jump;
    assign ID_EX_illegal  = idex_q.ctrl.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized traffic, checked against a
// behavioural model of the decode rules and the ID/EX update priorities.
module tb_id_stage;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_SLL = 4'd2, A_SLT = 4'd3;
    localparam logic [3:0] A_SLTU = 4'd4, A_XOR = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7;
    localparam logic [3:0] A_OR = 4'd8, A_AND = 4'd9, A_PASSB = 4'd10, A_PC4 = 4'd11;

    // ctl = {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, Branch, Jump, illegal}
    typedef struct packed {
        logic        valid;
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic [7:0]  ctl;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, IF_ID_enable, combined_stall, flush, wb_RegWrite;
    logic [31:0] IF_ID_PC, IF_ID_Instruction, rs1_rdata, rs2_rdata, wb_data;
    logic [4:0]  wb_rd, rs1_addr, rs2_addr;
    logic        load_use_stall, ID_EX_valid;
    logic [31:0] ID_EX_PC, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
    logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [2:0]  ID_EX_funct3;
    logic [3:0]  ID_EX_alu_op;
    logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg;
    logic        ID_EX_ALUSrc, ID_EX_Branch, ID_EX_Jump, ID_EX_illegal;

    logic [31:0] rf [32];
    exp_t        exp_s;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    always_comb begin
        rs1_rdata = rf[rs1_addr];
        rs2_rdata = rf[rs2_addr];
    end

    id_stage dut (
        .clk               (clk),
        .reset             (reset),
        .IF_ID_PC          (IF_ID_PC),
        .IF_ID_Instruction (IF_ID_Instruction),
        .IF_ID_enable      (IF_ID_enable),
        .combined_stall    (combined_stall),
        .flush             (flush),
        .rs1_addr          (rs1_addr),
        .rs2_addr          (rs2_addr),
        .rs1_rdata         (rs1_rdata),
        .rs2_rdata         (rs2_rdata),
        .wb_RegWrite       (wb_RegWrite),
        .wb_rd             (wb_rd),
        .wb_data           (wb_data),
        .load_use_stall    (load_use_stall),
        .ID_EX_valid       (ID_EX_valid),
        .ID_EX_PC          (ID_EX_PC),
        .ID_EX_rs1_data    (ID_EX_rs1_data),
        .ID_EX_rs2_data    (ID_EX_rs2_data),
        .ID_EX_imm         (ID_EX_imm),
        .ID_EX_rs1         (ID_EX_rs1),
        .ID_EX_rs2         (ID_EX_rs2),
        .ID_EX_rd          (ID_EX_rd),
        .ID_EX_funct3      (ID_EX_funct3),
        .ID_EX_alu_op      (ID_EX_alu_op),
        .ID_EX_RegWrite    (ID_EX_RegWrite),
        .ID_EX_MemRead     (ID_EX_MemRead),
        .ID_EX_MemWrite    (ID_EX_MemWrite),
        .ID_EX_MemToReg    (ID_EX_MemToReg),
        .ID_EX_ALUSrc      (ID_EX_ALUSrc),
        .ID_EX_Branch      (ID_EX_Branch),
        .ID_EX_Jump        (ID_EX_Jump),
        .ID_EX_illegal     (ID_EX_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    function automatic void model_decode(input logic [31:0] ins, output exp_t e,
                                         output logic u1, output logic u2);
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic       ok;
        logic [7:0] mask;
        logic [3:0] tab [8];
        logic [31:0] i_imm;
        tab = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        i_imm = 32'($signed(ins[31:20]));
        e = '0;
        u1 = 1'b0;
        u2 = 1'b0;
        ok = 1'b1;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd  = ins[11:7];
        e.f3  = f3;
        e.alu = A_ADD;
        case (op)
            7'h37: begin e.ctl = 8'b1000_1000; e.alu = A_PASSB; e.imm = {ins[31:12], 12'h0}; end
            7'h17: begin e.ctl = 8'b1000_1000; e.imm = {ins[31:12], 12'h0}; end
            7'h6F: begin
                e.ctl = 8'b1000_0010; e.alu = A_PC4;
                e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            end
            7'h67: begin
                e.ctl = 8'b1000_1010; e.alu = A_PC4; e.imm = i_imm; u1 = 1'b1; ok = (f3 == 0);
            end
            7'h63: begin
                e.ctl = 8'b0000_0100; e.alu = A_SUB; u1 = 1'b1; u2 = 1'b1; e.rd = 0;
                e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                mask = 8'b1111_0011; ok = mask[f3];
            end
            7'h03: begin
                e.ctl = 8'b1101_1000; e.imm = i_imm; u1 = 1'b1;
                mask = 8'b0011_0111; ok = mask[f3];
            end
            7'h23: begin
                e.ctl = 8'b0010_1000; u1 = 1'b1; u2 = 1'b1; e.rd = 0;
                e.imm = 32'($signed({ins[31:25], ins[11:7]}));
                mask = 8'b0000_0111; ok = mask[f3];
            end
            7'h13: begin
                e.ctl = 8'b1000_1000; e.imm = i_imm; u1 = 1'b1; e.alu = tab[f3];
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                if (f3 == 3'd5) begin
                    ok = (f7 == 7'h00) || (f7 == 7'h20);
                    if (f7 == 7'h20) e.alu = A_SRA;
                end
            end
            7'h33: begin
                e.ctl = 8'b1000_0000; u1 = 1'b1; u2 = 1'b1; e.alu = tab[f3];
                if (f7 == 7'h20) begin
                    ok = (f3 == 3'd0) || (f3 == 3'd5);
                    e.alu = (f3 == 3'd0) ? A_SUB : A_SRA;
                end else begin
                    ok = (f7 == 7'h00);
                end
            end
            7'h0F: begin e.imm = i_imm; ok = (f3 == 3'd0); end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.ctl = 8'b0000_0001; e.alu = A_ADD; u1 = 1'b0; u2 = 1'b0;
        end
    endfunction

    function automatic logic [31:0] opnd(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (wb_RegWrite && wb_rd == r) return wb_data;
        return rf[r];
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, ":valid"}, 32'(ID_EX_valid), 32'(exp_s.valid));
        chk({tag, ":pc"}, ID_EX_PC, exp_s.pc);
        chk({tag, ":d1"}, ID_EX_rs1_data, exp_s.d1);
        chk({tag, ":d2"}, ID_EX_rs2_data, exp_s.d2);
        chk({tag, ":imm"}, ID_EX_imm, exp_s.imm);
        chk({tag, ":idx"}, 32'({ID_EX_rs1, ID_EX_rs2, ID_EX_rd}),
            32'({exp_s.rs1, exp_s.rs2, exp_s.rd}));
        chk({tag, ":f3"}, 32'(ID_EX_funct3), 32'(exp_s.f3));
        chk({tag, ":alu"}, 32'(ID_EX_alu_op), 32'(exp_s.alu));
        chk({tag, ":ctl"}, 32'({ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg,
                                ID_EX_ALUSrc, ID_EX_Branch, ID_EX_Jump, ID_EX_illegal}),
            32'(exp_s.ctl));
    endtask

    // Inputs must already be driven; checks combinational outputs, clocks once, checks ID/EX.
    task automatic step(input string tag);
        exp_t dec, nxt;
        logic u1, u2, lus;
        #1;
        model_decode(IF_ID_Instruction, dec, u1, u2);
        lus = IF_ID_enable && exp_s.valid && exp_s.ctl[6] && (exp_s.rd != 0) &&
              ((u1 && exp_s.rd == dec.rs1) || (u2 && exp_s.rd == dec.rs2));
        chk({tag, ":lus"}, 32'(load_use_stall), 32'(lus));
        chk({tag, ":raddr"}, 32'({rs1_addr, rs2_addr}), 32'({dec.rs1, dec.rs2}));
        dec.valid = 1'b1;
        dec.pc    = IF_ID_PC;
        dec.d1    = opnd(dec.rs1);
        dec.d2    = opnd(dec.rs2);
        if (reset || flush)              nxt = '0;
        else if (combined_stall)         nxt = exp_s;
        else if (lus || !IF_ID_enable)   nxt = '0;
        else                             nxt = dec;
        @(posedge clk);
        #1;
        exp_s = nxt;
        check_regs(tag);
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] ins, input logic en);
        IF_ID_PC = pc;
        IF_ID_Instruction = ins;
        IF_ID_enable = en;
    endtask

    initial begin
        logic [6:0] pool [11];
        logic [31:0] ins;
        pool = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h03};
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'h1234_5678;
        exp_s = '0;
        reset = 1'b1; combined_stall = 1'b0; flush = 1'b0;
        wb_RegWrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        drive(32'h0, 32'h0000_0013, 1'b0);
        step("rst0");
        step("rst1");
        reset = 1'b0;

        drive(32'h100, 32'h0050_0093, 1'b1);
        step("addi5");
        chk("addi5:imm_k", ID_EX_imm, 32'd5);
        chk("addi5:rd_k", 32'(ID_EX_rd), 32'd1);
        chk("addi5:rw_alusrc_k", 32'({ID_EX_valid, ID_EX_RegWrite, ID_EX_ALUSrc}), 32'h7);
        chk("addi5:alu_k", 32'(ID_EX_alu_op), 32'(A_ADD));

        drive(32'h104, 32'hFFF0_0093, 1'b1);
        step("addim1");
        chk("addim1:imm_k", ID_EX_imm, 32'hFFFF_FFFF);

        drive(32'h108, 32'hFFDF_F0EF, 1'b1);
        step("jal");
        chk("jal:imm_k", ID_EX_imm, 32'hFFFF_FFFC);
        chk("jal:jump_k", 32'(ID_EX_Jump), 32'd1);

        drive(32'h10C, 32'h0000_A103, 1'b1);
        step("lw");
        drive(32'h110, 32'h0011_01B3, 1'b1);
        #1;
        chk("lu:stall_k", 32'(load_use_stall), 32'd1);
        step("lu_bubble");
        chk("lu:bubble_k", 32'(ID_EX_valid), 32'd0);
        step("lu_add");
        chk("lu:add_k", 32'({ID_EX_valid, ID_EX_rs1, ID_EX_rs2}), 32'({1'b1, 5'd2, 5'd1}));

        rf[1] = 32'h1111_1111;
        rf[2] = 32'd0;
        wb_RegWrite = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD_BEEF;
        step("byp");
        chk("byp:rs2_k", ID_EX_rs2_data, 32'hDEAD_BEEF);
        wb_rd = 5'd0;
        step("nobyp");
        chk("nobyp:rs2_k", ID_EX_rs2_data, 32'h1111_1111);
        wb_RegWrite = 1'b0;

        drive(32'h200, 32'h0050_0093, 1'b1);
        step("pre_stall");
        combined_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h204 + 32'(4 * i), 32'h0011_01B3, 1'b1);
            step("stall");
            chk("stall:pc_k", ID_EX_PC, 32'h200);
        end
        flush = 1'b1;
        step("flush_stall");
        chk("flush_stall:valid_k", 32'(ID_EX_valid), 32'd0);
        flush = 1'b0; combined_stall = 1'b0;

        drive(32'h300, 32'hFFFF_FFFF, 1'b1);
        step("illegal");
        chk("illegal:k", 32'({ID_EX_valid, ID_EX_illegal, ID_EX_RegWrite, ID_EX_MemRead,
                              ID_EX_MemWrite, ID_EX_Branch, ID_EX_Jump}), 32'h60);

        drive(32'h304, 32'h0000_A103, 1'b1);
        step("lw2");
        combined_stall = 1'b1; reset = 1'b1;
        step("rst_mid");
        chk("rst_mid:k", 32'({ID_EX_valid, ID_EX_MemRead}), 32'd0);
        chk("rst_mid:pc_k", ID_EX_PC, 32'd0);
        combined_stall = 1'b0; reset = 1'b0;

        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            ins[6:0] = pool[$urandom_range(0, 10)];
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            ins[11:7] = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) ins[31:25] = {1'b0, ins[30], 5'b0};
            drive($urandom, ins, $urandom_range(0, 9) != 0);
            combined_stall = ($urandom_range(0, 6) == 0);
            flush = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 49) == 0);
            wb_RegWrite = $urandom_range(0, 1) == 1;
            wb_rd = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            if ($urandom_range(0, 7) == 0) rf[$urandom_range(0, 31)] = $urandom;
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- RV32I decode stage, directly downstream of the instruction-fetch stage; consumes the IF/ID register (PC, instruction, enable).
- Decodes the instruction, generates the immediate, reads operands from the external register file with write-back bypass, and detects load-use hazards.
- Registers results into the ID/EX pipeline register consumed by the execute stage.

Parameters:
- XLEN, 32, datapath width
- NOP_INSN, 32'h00000013, canonical bubble instruction (addi x0,x0,0)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- IF_ID_PC  in  32  PC of fetched instruction
- IF_ID_Instruction  in  32  fetched instruction
- IF_ID_enable  in  1  IF/ID register holds a valid instruction
- combined_stall  in  1  downstream stall (e.g. d-cache miss); hold ID/EX
- flush  in  1  taken branch/jump resolved in EX; kill the current ID instruction
- rs1_addr, rs2_addr  out  5 each  register-file read addresses (combinational from the instruction)
- rs1_rdata, rs2_rdata  in  32 each  register-file read data (combinational)
- wb_RegWrite  in  1  write-back write enable
- wb_rd  in  5  write-back destination register
- wb_data  in  32  write-back data
- load_use_stall  out  1  combinational; OR'd into upstream combined_stall
- ID_EX_valid  out  1  ID/EX register holds a valid instruction
- ID_EX_PC  out  32  registered PC
- ID_EX_rs1_data, ID_EX_rs2_data  out  32 each  operand values
- ID_EX_imm  out  32  sign-extended immediate
- ID_EX_rs1, ID_EX_rs2, ID_EX_rd  out  5 each  register indices
- ID_EX_funct3  out  3  funct3 field
- ID_EX_alu_op  out  4  ALU operation code (package enum)
- ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_ALUSrc, ID_EX_Branch, ID_EX_Jump, ID_EX_illegal  out  1 each  control signals

Behaviour:
- Decode is combinational from IF_ID_Instruction. Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, FENCE (treated as NOP).
- Any other opcode, or an invalid funct3/funct7 combination, sets illegal=1 and forces all write/memory/branch controls to 0.
- Immediate formats I/S/B/U/J are sign-extended to 32 bits. U-type is imm[31:12]<<12. B and J immediates have bit0=0.
- rs1_used/rs2_used are decoded per format. U and J use neither; I-type and loads use rs1 only.
- Bypass: if wb_RegWrite && wb_rd!=0 && wb_rd==rsN_addr, the operand is wb_data; otherwise it is rsN_rdata. Register x0 always reads 0.
- load_use_stall = IF_ID_enable && ID_EX_valid && ID_EX_MemRead && ID_EX_rd!=0 && ((rs1_used && ID_EX_rd==rs1) || (rs2_used && ID_EX_rd==rs2)).
- Latency: 1 cycle from a valid IF/ID word to ID/EX.
- ID/EX update on posedge clk, in priority order:
  1. reset: ID_EX_valid=0; all control outputs 0; ID_EX_PC, data, imm, indices, funct3 = 0; alu_op = ADD.
  2. flush: bubble (valid=0, all controls 0); data fields don't-care but driven 0.
  3. combined_stall: hold every ID/EX output unchanged. Flush takes precedence over a simultaneous stall.
  4. load_use_stall: insert a bubble (valid=0, controls 0). The IF stage holds via the stall, and the same instruction re-decodes next cycle.
  5. IF_ID_enable=0: insert a bubble.
  6. Otherwise: latch the decoded instruction with valid=1.
- A bubble never asserts RegWrite, MemRead, MemWrite, Branch or Jump.
- An illegal instruction propagates with valid=1 and illegal=1, so EX/trap logic reports it.
- rd is forced to 0 for formats with no destination (S, B), so hazard compares stay clean.
- A reset asserted mid-stall clears the stall effect immediately. load_use_stall deasserts in the reset cycle's output because ID_EX_valid=0 after reset.

Decomposition:
- Shared package rv32_pkg holds:
  - opcode constants (OPC_LUI … OPC_FENCE)
  - funct3/funct7 constants
  - alu_op enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB, PC4
  - NOP_INSN
- One sub-module: imm_gen, a purely combinational instruction-to-immediate converter, reused later by the branch unit.

Test Plan:
- addi x1,x0,5 (0x00500093), IF_ID_enable=1 → next cycle ID_EX_valid=1, imm=5, rd=1, RegWrite=1, ALUSrc=1, alu_op=ADD.
- addi x1,x0,-1 (0xFFF00093) → ID_EX_imm=0xFFFFFFFF. jal with offset -4 → imm=0xFFFFFFFC, Jump=1.
- lw x2,0(x1) (0x0000A103) then add x3,x2,x1 (0x001101B3) → load_use_stall=1 for one cycle, one bubble (valid=0) emitted, then add latched with rs1=2, rs2=1.
- wb_RegWrite=1, wb_rd=1, wb_data=0xDEADBEEF, rs1_rdata=0 while decoding add x3,x2,x1 → ID_EX_rs2_data=0xDEADBEEF. With wb_rd=0 → no bypass.
- combined_stall=1 for 3 cycles with new IF_ID input → ID/EX outputs unchanged. flush and combined_stall together → bubble.
- Instruction 0xFFFFFFFF → ID_EX_valid=1, illegal=1, RegWrite=MemRead=MemWrite=Branch=Jump=0. Reset asserted mid-sequence → all outputs at reset values next cycle.
